guess_scorer: RTL

Turn scorer and guess history for the Bulls & Cows game. It sits directly downstream of the game-control FSM. When that FSM enters its calculate state, this block takes the completed secret and guess. It computes the A (right digit, right position) and B (right digit, wrong position) counts by serial pairwise comparison. It then drives `count_a` back to the FSM's `Count_A_in` and records each turn's guess and score in a small history buffer for the display path.

---
 rtl/guess_scorer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/guess_scorer.sv
// Bulls & Cows turn scorer: serially compares a snapshotted guess against the
// secret (16 digit pairs), reports A/B counts and keeps a per-turn history.
module guess_scorer #(
    parameter int HIST_DEPTH = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        clear,
    input  logic        start,
    input  logic [15:0] secret_flat,
    input  logic [15:0] guess_flat,
    input  logic [2:0]  turn_in,
    output logic        busy,
    output logic        done,
    output logic [2:0]  count_a,
    output logic [2:0]  count_b,
    output logic [2:0]  hist_count,
    input  logic [2:0]  hist_rd_idx,
    output logic [15:0] hist_rd_guess,
    output logic [2:0]  hist_rd_a,
    output logic [2:0]  hist_rd_b,
    output logic        hist_rd_valid
);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      pair_q, pair_d;
    logic [15:0]     secret_q, secret_d;
    logic [15:0]     guess_q, guess_d;
    logic [2:0]      acc_a_q, acc_a_d;
    logic [2:0]      acc_b_q, acc_b_d;
    logic [2:0]      count_a_q, count_a_d;
    logic [2:0]      count_b_q, count_b_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [HIST_DEPTH-1:0] valid_q, valid_d;
    logic [2:0]      hist_count_q, hist_count_d;
    logic [15:0]     rd_guess_q, rd_guess_d;
    logic [2:0]      rd_a_q, rd_a_d;
    logic [2:0]      rd_b_q, rd_b_d;
    logic            rd_valid_q, rd_valid_d;
    logic            wr_en;
    logic [3:0]      g_dig, s_dig;
    logic            soft_rst;

    logic [15:0]     hist_guess_q [HIST_DEPTH];
    logic [2:0]      hist_a_q     [HIST_DEPTH];
    logic [2:0]      hist_b_q     [HIST_DEPTH];

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    // Blank digits (values above 9) never match anything, including another blank.
    function automatic logic digit_match(input logic [3:0] g, input logic [3:0] s);
        return (g <= 4'd9) && (g == s);
    endfunction

    assign soft_rst = RESET | clear;

    always_comb begin
        state_d   = state_q;
        pair_d    = pair_q;
        secret_d  = secret_q;
        guess_d   = guess_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        count_a_d = count_a_q;
        count_b_d = count_b_q;
        valid_d   = valid_q;
        wr_en     = 1'b0;
        g_dig     = guess_q[{pair_q[3:2], 2'b00} +: 4];
        s_dig     = secret_q[{pair_q[1:0], 2'b00} +: 4];

        case (state_q)
            // DONE is the one-cycle result pulse; it accepts start like IDLE so
            // back-to-back turns can launch on the cycle the result appears.
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    secret_d  = secret_flat;
                    guess_d   = guess_flat;
                    acc_a_d   = 3'd0;
                    acc_b_d   = 3'd0;
                    count_a_d = 3'd0;
                    count_b_d = 3'd0;
                    pair_d    = 4'd0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (digit_match(g_dig, s_dig)) begin
                    if (pair_q[3:2] == pair_q[1:0]) acc_a_d = sat_inc(acc_a_q);
                    else                            acc_b_d = sat_inc(acc_b_q);
                end
                pair_d = pair_q + 4'd1;
                if (pair_q == 4'hF) state_d = WRITE;
            end
            WRITE: begin
                count_a_d = acc_a_q;
                count_b_d = acc_b_q;
                if (int'(turn_in) < HIST_DEPTH) begin
                    wr_en            = 1'b1;
                    valid_d[turn_in] = 1'b1;
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (soft_rst) wr_en = 1'b0;

        busy_d = (state_d == SCAN) || (state_d == WRITE);
        done_d = (state_d == DONE);

        hist_count_d = 3'd0;
        for (int k = 0; k < HIST_DEPTH; k++) begin
            hist_count_d = hist_count_d + {2'b00, valid_d[k]};
        end
    end

    // Read port samples the array before any same-cycle write lands.
    always_comb begin
        rd_guess_d = 16'd0;
        rd_a_d     = 3'd0;
        rd_b_d     = 3'd0;
        rd_valid_d = 1'b0;
        if (int'(hist_rd_idx) < HIST_DEPTH) begin
            if (valid_q[hist_rd_idx]) begin
                rd_guess_d = hist_guess_q[hist_rd_idx];
                rd_a_d     = hist_a_q[hist_rd_idx];
                rd_b_d     = hist_b_q[hist_rd_idx];
                rd_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (soft_rst) begin
            state_q      <= IDLE;
            pair_q       <= 4'd0;
            count_a_q    <= 3'd0;
            count_b_q    <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= '0;
            hist_count_q <= 3'd0;
            rd_guess_q   <= 16'd0;
            rd_a_q       <= 3'd0;
            rd_b_q       <= 3'd0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pair_q       <= pair_d;
            count_a_q    <= count_a_d;
            count_b_q    <= count_b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            hist_count_q <= hist_count_d;
            rd_guess_q   <= rd_guess_d;
            rd_a_q       <= rd_a_d;
            rd_b_q       <= rd_b_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        secret_q <= secret_d;
        guess_q  <= guess_d;
        acc_a_q  <= acc_a_d;
        acc_b_q  <= acc_b_d;
        if (wr_en) begin
            hist_guess_q[turn_in] <= guess_q;
            hist_a_q[turn_in]     <= acc_a_q;
            hist_b_q[turn_in]     <= acc_b_q;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign count_a       = count_a_q;
    assign count_b       = count_b_q;
    assign hist_count    = hist_count_q;
    assign hist_rd_guess = rd_guess_q;
    assign hist_rd_a     = rd_a_q;
    assign hist_rd_b     = rd_b_q;
    assign hist_rd_valid = rd_valid_q;

endmodule
